mux_arbiter: RTL

Round-robin arbiter that shares one 4:1 single-bit mux path among four requesters. It drives the mux select pair (s1, s0) and the mux Enable, and presents the selected data bit on y. It sits in front of the 4:1 mux datapath, replacing static select wiring with time-shared, fair access. Grants are bounded in length by a hold counter, so one requester cannot starve the others.

---
 rtl/mux_arb_pkg.sv | 20 ++
 rtl/mux_arbiter_rr_pick.sv | 33 +++
 rtl/mux_arbiter.sv | 119 +++++++++++
 3 files changed

// File: rtl/mux_arb_pkg.sv
// Shared definitions for the round-robin mux arbiter: state encoding,
// requester count, index width and a one-hot helper.
package mux_arb_pkg;

   localparam int N_REQ = 4;
   localparam int IDX_W = 2;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_GRANT = 2'd1;
   localparam logic [1:0] ST_GAP   = 2'd2;

   // Turn a requester index into its one-hot grant vector.
   function automatic logic [N_REQ-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
      logic [N_REQ-1:0] oh;
      oh      = '0;
      oh[idx] = 1'b1;
      return oh;
   endfunction

endpackage

// File: rtl/mux_arbiter_rr_pick.sv
// Combinational round-robin picker. Searches last+1, last+2, last+3, last
// (mod 4) and returns the first requester that is set and not excluded.
module rr_pick
   import mux_arb_pkg::*;
(
   input  logic [N_REQ-1:0] req,
   input  logic [IDX_W-1:0] last,
   input  logic [N_REQ-1:0] excl,
   output logic             any,
   output logic [IDX_W-1:0] idx
);

   logic [N_REQ-1:0] cand;
   logic [IDX_W-1:0] pos;

   assign cand = req & ~excl;

   // Walk the search order; the first candidate found wins.
   always_comb begin
      // NOTE: every output of a combinational block gets a default first so no latch is inferred.
      any = 1'b0;
      idx = last;
      pos = '0;
      for (int k = 1; k <= N_REQ; k++) begin
         pos = last + IDX_W'(k);
         if (!any && cand[pos]) begin
            any = 1'b1;
            idx = pos;
         end
      end
   end

endmodule

// File: rtl/mux_arbiter.sv
// Round-robin arbiter sharing one 4:1 single-bit mux among four requesters.
// Drives the registered mux select {s1,s0}, Enable and one-hot gnt, and gates
// the selected data bit onto y. Grants are bounded by a hold counter while
// another requester waits.
// Optional feature: define MUX_ARB_GAP_EN to insert one dead cycle
// (Enable=0) at every release (break-before-make between owners).
module mux_arbiter
   import mux_arb_pkg::*;
#(
   parameter int MAX_HOLD = 8,
   parameter int CNT_W    = 8
)
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N_REQ-1:0] req,
   input  logic [N_REQ-1:0] d_in,
   output logic [N_REQ-1:0] gnt,
   output logic             s1,
   output logic             s0,
   output logic             Enable,
   output logic             y,
   output logic             busy
);

   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

   logic [1:0]       state;
   logic [IDX_W-1:0] last;
   logic [CNT_W-1:0] hold_cnt;
   logic [IDX_W-1:0] owner;
   logic [N_REQ-1:0] owner_oh;
   logic             hold_end;
   logic             others;
   logic             rel_a;
   logic             rel_b;
   logic [N_REQ-1:0] excl;
   logic             pick_any;
   logic [IDX_W-1:0] pick_idx;

   assign owner    = {s1, s0};
   assign owner_oh = idx_to_onehot(owner);
   assign hold_end = (hold_cnt == HOLD_LAST);
   assign others   = |(req & ~owner_oh);

   // Release conditions: owner dropped its request (a) takes precedence over
   // hold expiry with a competitor waiting (b); only (b) excludes the owner.
   assign rel_a = (state == ST_GRANT) && !req[owner];
   assign rel_b = (state == ST_GRANT) && hold_end && others && !rel_a;
   assign excl  = rel_b ? owner_oh : '0;

   rr_pick u_pick (
      .req  (req),
      .last (last),
      .excl (excl),
      .any  (pick_any),
      .idx  (pick_idx)
   );

   // Arbitration FSM with hold counter, round-robin pointer and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_IDLE;
         gnt      <= '0;
         s1       <= 1'b0;
         s0       <= 1'b0;
         Enable   <= 1'b0;
         last     <= IDX_W'(N_REQ - 1);
         hold_cnt <= '0;
      end else begin
         // NOTE: state registers use non-blocking assignments so every register samples pre-edge values.
         case (state)
            ST_GRANT: begin
               if (rel_a || rel_b) begin
`ifdef MUX_ARB_GAP_EN
                  state  <= ST_GAP;
                  gnt    <= '0;
                  Enable <= 1'b0;
`else
                  if (pick_any) begin
                     state    <= ST_GRANT;
                     gnt      <= idx_to_onehot(pick_idx);
                     {s1, s0} <= pick_idx;
                     last     <= pick_idx;
                     hold_cnt <= '0;
                     Enable   <= 1'b1;
                  end else begin
                     state  <= ST_IDLE;
                     gnt    <= '0;
                     Enable <= 1'b0;
                  end
`endif
               end else begin
                  hold_cnt <= hold_end ? '0 : hold_cnt + 1'b1;
               end
            end
            default: begin
               if (pick_any) begin
                  state    <= ST_GRANT;
                  gnt      <= idx_to_onehot(pick_idx);
                  {s1, s0} <= pick_idx;
                  last     <= pick_idx;
                  hold_cnt <= '0;
                  Enable   <= 1'b1;
               end else begin
                  state  <= ST_IDLE;
                  gnt    <= '0;
                  Enable <= 1'b0;
               end
            end
         endcase
      end
   end

   // Data path and status: y is forced low whenever the mux is disabled.
   assign y    = Enable & d_in[owner];
   assign busy = (state == ST_GRANT) || (state == ST_GAP);

endmodule
